maf_issue_ctrl: RTL
===================

// Module: maf_issue_ctrl
// PURPOSE
//  Multi-lane issue/collect controller between the test/stimulus side and an array of LANES maf units.
//  Issues operand triples to the maf array with a valid/ready handshake and per-lane enable.
//  Tags each op, limits in-flight work by credits, and buffers in-order maf results in a FIFO.
//  Results are returned under backpressure, so results are never dropped.
// PARAMETERS
//  LANES      4   number of maf lanes driven in lockstep
//  W          32  operand/result width per lane (bits)
//  DEPTH      8   result FIFO depth = max ops in flight + buffered (power of 2, >=2)
//  TAG_W      4   op tag width; tag wraps modulo 2**TAG_W
// PORTS
//  clk          in   1        clock, all logic on rising edge
//  rst          in   1        synchronous, active-high reset
//  nj_mode_cfg  in   1        nj mode request; sampled only when idle
//  in_vld       in   1        op offered
//  in_rdy       out  1        controller can accept op
//  in_lane_en   in   LANES    per-lane enable of offered op
//  in_a/b/c     in   LANES*W  operands, lane i at [i*W +: W]
//  maf_op_vld   out  1        issue strobe to all maf lanes
//  maf_nj_mode  out  1        latched nj mode to maf lanes
//  maf_a/b/c    out  LANES*W  registered operands to maf lanes
//  maf_res      in   LANES*W  maf results
//  maf_res_rdy  in   1        maf result strobe (lane 0 representative; lanes lockstep)
//  out_vld      out  1        result at FIFO head valid
//  out_rdy      in   1        consumer accepts result
//  out_res      out  LANES*W  result; disabled lanes forced to 0
//  out_lane_en  out  LANES    lane enables of the op
//  out_tag      out  TAG_W    tag of the op
//  busy         out  1        inflight+fifo_cnt != 0
//  err_spur     out  1        sticky: maf_res_rdy seen with inflight==0
// BEHAVIOUR
//  Reset (rst=1 at clk edge): in_rdy=0 that cycle; maf_op_vld=0; maf_a/b/c=0; maf_nj_mode=1;
//   out_vld=0; out_res=0; out_lane_en=0; out_tag=0; busy=0; err_spur=0; tag_ctr=0; inflight=0; FIFO empty.
//   Reset mid-operation discards all in-flight and buffered ops; later maf_res_rdy strobes set err_spur.
//  Accept: acc = in_vld & in_rdy; in_rdy = !rst & (inflight + fifo_cnt < DEPTH).
//  Issue: cycle after acc, maf_op_vld=1 for exactly one cycle with maf_a/b/c = registered in_a/b/c.
//   Disabled lanes still issue operands (lockstep); masking is applied on output only.
//  Meta queue (DEPTH entries): on acc push {tag_ctr, in_lane_en}; tag_ctr <= tag_ctr+1 (wraps).
//  Collect: maf_res_rdy & inflight>0 -> pop meta, push {tag, lane_en, maf_res} into result FIFO same edge.
//   maf_res_rdy & inflight==0 -> result ignored, err_spur <= 1 (clears only on rst).
//  inflight: +1 on acc, -1 on valid collect; simultaneous -> unchanged. Credit rule guarantees FIFO never
//   overflows: no push is ever blocked, independent of maf latency.
//  Output: FIFO is first-word-fall-through; out_vld = !empty; pop on out_vld & out_rdy.
//   Push and pop same cycle: count unchanged. Push into empty FIFO: out_vld next cycle (1-cycle min).
//  Ordering: results leave strictly in acceptance order; out_tag sequential modulo 2**TAG_W.
//  nj mode: maf_nj_mode <= nj_mode_cfg only when busy==0 & !acc; else held.
//  Full: inflight+fifo_cnt==DEPTH -> in_rdy=0; rises the cycle after a pop.
//  Throughput: 1 op/cycle sustained when out_rdy=1 and DEPTH > maf latency+1.
//  Width rules: counters clog2(DEPTH)+1 bits; no arithmetic on data path.
// TESTING
//  1 rst, in_vld with lane_en=4'hF, a/b/c lane0 = 3f800000/40000000/40400000, maf model lat 5
//    -> maf_op_vld 1 cycle later, out_vld, out_tag=0, lane0 result = 40a00000.
//  2 out_rdy=0, 10 back-to-back ops, DEPTH=8 -> exactly 8 accepted, in_rdy=0;
//    out_rdy=1 -> 10 results tags 0..9 in order, none lost.
//  3 lane_en=4'b0101 -> out_res lanes 1,3 = 0; lanes 0,2 = model values; out_lane_en=4'b0101.
//  4 20 ops with TAG_W=4 -> tags 0..15,0..3 (wrap); simultaneous push/pop keeps count correct.
//  5 maf_res_rdy pulse with nothing in flight -> err_spur=1, FIFO unchanged; stays 1 until rst.
//  6 rst asserted with 3 in flight, 2 buffered -> all outputs at reset values next cycle;
//    nj_mode_cfg=0 changed while busy -> maf_nj_mode stays 1 until idle.

Source files
------------

// File: rtl/maf_issue_ctrl.sv
// -----------------------------------------------------------------------------
// maf_issue_ctrl
//   Issue/collect controller sitting between a stimulus source and an array of
//   LANES maf units that run in lockstep. Operand triples are accepted with a
//   valid/ready handshake, registered and issued to all lanes as a one-cycle
//   strobe. Each op is tagged, and the tag and lane enables are held in a meta
//   queue. Returning results pick up that meta data and go into a
//   first-word-fall-through result FIFO.
//
//   Credits bound the work in the system: inflight + fifo_cnt never exceeds
//   DEPTH. The result FIFO therefore always has room for a returning result,
//   whatever the maf latency, and results are never dropped.
//
// Ports
//   clk, rst              clock; synchronous active-high reset
//   nj_mode_cfg           nj mode request, taken over only while idle
//   in_vld/in_rdy         op handshake; in_lane_en, in_a/b/c op payload
//   maf_op_vld            one-cycle issue strobe to all lanes
//   maf_nj_mode           latched nj mode
//   maf_a/b/c             registered operands (lane i at [i*W +: W])
//   maf_res/maf_res_rdy   results returning from the lanes, in order
//   out_vld/out_rdy       result handshake; out_res/out_lane_en/out_tag payload
//   busy                  ops in flight or buffered
//   err_spur              sticky: result strobe seen with nothing in flight
// -----------------------------------------------------------------------------
module maf_issue_ctrl #(
  parameter int LANES = 4,
  parameter int W     = 32,
  parameter int DEPTH = 8,
  parameter int TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 nj_mode_cfg,
  input  logic                 in_vld,
  output logic                 in_rdy,
  input  logic [LANES-1:0]     in_lane_en,
  input  logic [LANES*W-1:0]   in_a,
  input  logic [LANES*W-1:0]   in_b,
  input  logic [LANES*W-1:0]   in_c,
  output logic                 maf_op_vld,
  output logic                 maf_nj_mode,
  output logic [LANES*W-1:0]   maf_a,
  output logic [LANES*W-1:0]   maf_b,
  output logic [LANES*W-1:0]   maf_c,
  input  logic [LANES*W-1:0]   maf_res,
  input  logic                 maf_res_rdy,
  output logic                 out_vld,
  input  logic                 out_rdy,
  output logic [LANES*W-1:0]   out_res,
  output logic [LANES-1:0]     out_lane_en,
  output logic [TAG_W-1:0]     out_tag,
  output logic                 busy,
  output logic                 err_spur
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int MW = TAG_W + LANES;
  localparam int RW = MW + LANES*W;

  // Control state
  logic [CW-1:0]      inflight_q, inflight_d;
  logic [CW-1:0]      fifo_cnt_q, fifo_cnt_d;
  logic [TAG_W-1:0]   tag_q;
  logic [AW-1:0]      meta_wr_q, meta_rd_q;
  logic [AW-1:0]      res_wr_q, res_rd_q;
  logic               maf_op_vld_q;
  logic               nj_q;
  logic               err_q;
  logic [LANES*W-1:0] maf_a_q, maf_b_q, maf_c_q;

  // Storage (contents are only observed behind valid counts, so no reset)
  logic [MW-1:0]      meta_mem_q [DEPTH];
  logic [RW-1:0]      res_mem_q  [DEPTH];

  // Combinational helpers
  logic [CW-1:0]      occ_s;
  logic               acc_s;
  logic               collect_s;
  logic               spur_s;
  logic               pop_s;
  logic               busy_s;
  logic [MW-1:0]      meta_head_s;
  logic [LANES*W-1:0] masked_res_s;
  logic [RW-1:0]      res_head_s;

  assign occ_s       = inflight_q + fifo_cnt_q;
  assign in_rdy      = !rst && (occ_s < CW'(DEPTH));
  assign acc_s       = in_vld && in_rdy;
  assign collect_s   = maf_res_rdy && (inflight_q != {CW{1'b0}});
  assign spur_s      = maf_res_rdy && (inflight_q == {CW{1'b0}});
  assign out_vld     = (fifo_cnt_q != {CW{1'b0}});
  assign pop_s       = out_vld && out_rdy;
  assign busy_s      = (occ_s != {CW{1'b0}});
  assign meta_head_s = meta_mem_q[meta_rd_q];
  assign res_head_s  = res_mem_q[res_rd_q];

  // Lanes always compute in lockstep; disabled lanes are zeroed when the
  // result is captured, using the enables of the op at the meta queue head.
  always_comb begin
    masked_res_s = {(LANES*W){1'b0}};
    for (int i = 0; i < LANES; i++) begin
      if (meta_head_s[i]) begin
        masked_res_s[i*W +: W] = maf_res[i*W +: W];
      end else begin
        masked_res_s[i*W +: W] = {W{1'b0}};
      end
    end
  end

  // Credit and FIFO occupancy next-state; simultaneous +1/-1 cancel out.
  always_comb begin
    inflight_d = inflight_q;
    fifo_cnt_d = fifo_cnt_q;
    case ({acc_s, collect_s})
      2'b10:   inflight_d = inflight_q + CW'(1);
      2'b01:   inflight_d = inflight_q - CW'(1);
      default: inflight_d = inflight_q;
    endcase
    case ({collect_s, pop_s})
      2'b10:   fifo_cnt_d = fifo_cnt_q + CW'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - CW'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  // Control registers, issue stage and sticky/mode flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q   <= {CW{1'b0}};
      fifo_cnt_q   <= {CW{1'b0}};
      tag_q        <= {TAG_W{1'b0}};
      meta_wr_q    <= {AW{1'b0}};
      meta_rd_q    <= {AW{1'b0}};
      res_wr_q     <= {AW{1'b0}};
      res_rd_q     <= {AW{1'b0}};
      maf_op_vld_q <= 1'b0;
      nj_q         <= 1'b1;
      err_q        <= 1'b0;
      maf_a_q      <= {(LANES*W){1'b0}};
      maf_b_q      <= {(LANES*W){1'b0}};
      maf_c_q      <= {(LANES*W){1'b0}};
    end else begin
      inflight_q   <= inflight_d;
      fifo_cnt_q   <= fifo_cnt_d;
      maf_op_vld_q <= acc_s;
      if (acc_s) begin
        tag_q     <= tag_q + TAG_W'(1);
        meta_wr_q <= meta_wr_q + AW'(1);
        maf_a_q   <= in_a;
        maf_b_q   <= in_b;
        maf_c_q   <= in_c;
      end
      if (collect_s) begin
        meta_rd_q <= meta_rd_q + AW'(1);
        res_wr_q  <= res_wr_q + AW'(1);
      end
      if (pop_s) begin
        res_rd_q <= res_rd_q + AW'(1);
      end
      if (spur_s) begin
        err_q <= 1'b1;
      end
      // Mode may only change while nothing is in flight, buffered or arriving.
      if (!busy_s && !acc_s) begin
        nj_q <= nj_mode_cfg;
      end
    end
  end

  // Meta queue and result FIFO storage writes.
  always_ff @(posedge clk) begin
    if (acc_s) begin
      meta_mem_q[meta_wr_q] <= {tag_q, in_lane_en};
    end
    if (collect_s) begin
      res_mem_q[res_wr_q] <= {meta_head_s, masked_res_s};
    end
  end

  assign maf_op_vld  = maf_op_vld_q;
  assign maf_nj_mode = nj_q;
  assign maf_a       = maf_a_q;
  assign maf_b       = maf_b_q;
  assign maf_c       = maf_c_q;
  assign busy        = busy_s;
  assign err_spur    = err_q;
  // Head fields read as zero while the FIFO is empty.
  assign out_tag     = out_vld ? res_head_s[RW-1 -: TAG_W]      : {TAG_W{1'b0}};
  assign out_lane_en = out_vld ? res_head_s[LANES*W +: LANES]   : {LANES{1'b0}};
  assign out_res     = out_vld ? res_head_s[LANES*W-1:0]        : {(LANES*W){1'b0}};

endmodule
